// File: rtl/pulse_stretcher_mc_if.sv
// Bundle between pulse_stretcher_mc and its user: shared trigger config, per-channel events and strobes.
// drop_cnt exists only when DROP_CNT_EN is defined.
interface pulse_stretcher_mc_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 10
);
  logic                  en;
  logic [1:0]            edge_sel;
  logic                  retrig;
  logic [CNT_W-1:0]      width;
  logic [CHANNELS-1:0]   a;
  logic [CHANNELS-1:0]   b;
  logic [CHANNELS-1:0]   busy;
`ifdef DROP_CNT_EN
  logic [CHANNELS*8-1:0] drop_cnt;
`endif

  modport master (
    output en, edge_sel, retrig, width, a,
    input  b, busy
`ifdef DROP_CNT_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  en, edge_sel, retrig, width, a,
    output b, busy
`ifdef DROP_CNT_EN
    , output drop_cnt
`endif
  );
endinterface

// File: rtl/pulse_stretcher_mc.sv
// Multi-channel sync + edge-detect one-shot: b follows the a edge by SYNC_STAGES+DELAY cycles, busy by SYNC_STAGES.
// No backpressure; triggers arriving while a channel is busy are reloaded or dropped (counted when DROP_CNT_EN).
module pulse_stretcher_mc #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DELAY       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pulse_stretcher_mc_if.slave   ps
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
  logic [CHANNELS-1:0]    hist_q, hist_d;
  logic [CHANNELS-1:0]    rise, fall, trig;
  logic                   sel_rise, sel_fall;

  state_e                 state_q [CHANNELS];
  state_e                 state_d [CHANNELS];
  logic [CHANNELS-1:0]    o_q, o_d;
  logic [CNT_W-1:0]       cnt_q [CHANNELS];
  logic [CNT_W-1:0]       cnt_d [CHANNELS];
  logic [CNT_W-1:0]       width_m1;
  logic                   width_nz;

  assign width_m1 = ps.width - CNT_W'(1);
  assign width_nz = |ps.width;
  assign sel_rise = ps.en & ((ps.edge_sel == 2'b00) | (ps.edge_sel == 2'b10));
  assign sel_fall = ps.en & ((ps.edge_sel == 2'b01) | (ps.edge_sel == 2'b10));

  always_comb begin
    sync_d = sync_q;
    hist_d = hist_q;
    rise   = '0;
    fall   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], ps.a[i]};
      hist_d[i] = sync_q[i][SYNC_STAGES-1];
      rise[i]   = sync_q[i][SYNC_STAGES-1] & ~hist_q[i];
      fall[i]   = ~sync_q[i][SYNC_STAGES-1] & hist_q[i];
    end
    trig = (rise & {CHANNELS{sel_rise}}) | (fall & {CHANNELS{sel_fall}});
  end

  // The terminal cnt==0 cycle always returns to IDLE, forcing a low gap between pulses.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      case (state_q[i])
        ST_IDLE: begin
          if (trig[i] && width_nz) begin
            state_d[i] = ST_ACTIVE;
            o_d[i]     = 1'b1;
            cnt_d[i]   = width_m1;
          end
        end
        ST_ACTIVE: begin
          if ((cnt_q[i] == '0) || (ps.retrig && trig[i] && !width_nz)) begin
            state_d[i] = ST_IDLE;
            o_d[i]     = 1'b0;
          end else if (ps.retrig && trig[i]) begin
            cnt_d[i] = width_m1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          o_d[i]     = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ps.busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ps.busy[i] = (state_q[i] == ST_ACTIVE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      hist_q <= '0;
      o_q    <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i]  <= sync_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      hist_q <= hist_d;
      o_q    <= o_d;
    end
  end

  generate
    if (DELAY == 0) begin : g_nodly
      always_comb begin
        ps.b = o_q;
      end
    end else begin : g_dly
      logic [DELAY-1:0] dly_q [CHANNELS];
      logic [DELAY-1:0] dly_d [CHANNELS];

      always_comb begin
        dly_d = dly_q;
        ps.b  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
          dly_d[i] = (dly_q[i] << 1) | DELAY'(o_q[i]);
          ps.b[i]  = dly_q[i][DELAY-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < CHANNELS; i++) dly_q[i] <= '0;
        end else begin
          for (int i = 0; i < CHANNELS; i++) dly_q[i] <= dly_d[i];
        end
      end
    end
  endgenerate

`ifdef DROP_CNT_EN
  // A trigger is lost when active and it cannot reload: retrig off, or on the terminal cycle.
  logic [CHANNELS-1:0] ignored;
  logic [7:0]          drop_q [CHANNELS];
  logic [7:0]          drop_d [CHANNELS];

  always_comb begin
    ignored     = '0;
    drop_d      = drop_q;
    ps.drop_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ignored[i] = (state_q[i] == ST_ACTIVE) & trig[i] & ((cnt_q[i] == '0) | ~ps.retrig);
      if (ignored[i] && (drop_q[i] != 8'hFF)) drop_d[i] = drop_q[i] + 8'd1;
      ps.drop_cnt[8*i +: 8] = drop_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) drop_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) drop_q[i] <= drop_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_pulse_stretcher_mc.sv
// Bench for pulse_stretcher_mc: end-time pulse model compared every cycle, plus directed literal checks.
module tb_pulse_stretcher_mc;
  localparam int CH = 4;
  localparam int CW = 10;
  localparam int SS = 2;
  localparam int DL = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pulse_stretcher_mc_if #(.CHANNELS(CH), .CNT_W(CW)) ifc ();

  pulse_stretcher_mc #(
    .CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS), .DELAY(DL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ps    (ifc)
  );

  // Model: a channel is high from its start edge through end_e; b is that level DL edges later.
  bit [SS:0]       ahist [CH];
  bit              hi    [CH];
  int              end_e [CH];
  bit [DL:0]       ohist [CH];
  int              drops [CH];
  int              cyc;
  logic [CH-1:0]   exp_b, exp_busy;
  logic [CH*8-1:0] exp_drop;

  initial begin : model
    bit rise, fall, trg;
    int w;
    cyc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int c = 0; c < CH; c++) begin
          ahist[c] = '0; hi[c] = 1'b0; ohist[c] = '0; drops[c] = 0; end_e[c] = 0;
        end
      end else begin
        cyc++;
        w = int'(ifc.width);
        for (int c = 0; c < CH; c++) begin
          rise = ahist[c][SS-1] && !ahist[c][SS];
          fall = !ahist[c][SS-1] && ahist[c][SS];
          case (ifc.edge_sel)
            2'b00:   trg = rise;
            2'b01:   trg = fall;
            2'b10:   trg = rise || fall;
            default: trg = 1'b0;
          endcase
          trg = trg && ifc.en;
          if (!hi[c]) begin
            if (trg && w != 0) begin hi[c] = 1'b1; end_e[c] = cyc + w - 1; end
          end else if (cyc == end_e[c] + 1) begin
            hi[c] = 1'b0;
            if (trg && drops[c] < 255) drops[c]++;
          end else if (trg && ifc.retrig) begin
            if (w != 0) end_e[c] = cyc + w - 1;
            else        hi[c] = 1'b0;
          end else if (trg) begin
            if (drops[c] < 255) drops[c]++;
          end
          ahist[c] = {ahist[c][SS-1:0], ifc.a[c]};
          ohist[c] = {ohist[c][DL-1:0], hi[c]};
        end
      end
      for (int c = 0; c < CH; c++) begin
        exp_busy[c]       = hi[c];
        exp_b[c]          = ohist[c][DL];
        exp_drop[8*c +: 8] = 8'(drops[c]);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        checks++;
        if (ifc.b !== exp_b || ifc.busy !== exp_busy) begin
          errors++;
          $display("FAIL cycle_cmp t=%0t got b=%b busy=%b want b=%b busy=%b",
                   $time, ifc.b, ifc.busy, exp_b, exp_busy);
        end
`ifdef DROP_CNT_EN
        checks++;
        if (ifc.drop_cnt !== exp_drop) begin
          errors++;
          $display("FAIL drop_cmp t=%0t got %h want %h", $time, ifc.drop_cnt, exp_drop);
        end
`endif
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // t=0 is the edge that samples the a change made just before the call.
  task automatic measure(input int ch, output int bst, output int blen,
                         output int yst, output int ylen, output int npulse);
    bit prev_b;
    bst = -1; yst = -1; blen = 0; ylen = 0; npulse = 0; prev_b = 1'b0;
    for (int t = 0; t < 1200; t++) begin
      @(posedge clk); #1;
      if (ifc.busy[ch]) begin if (yst < 0) yst = t; ylen++; end
      if (ifc.b[ch]) begin
        if (bst < 0) bst = t;
        blen++;
        if (!prev_b) npulse++;
      end
      if (bst >= 0 && !ifc.b[ch] && !ifc.busy[ch]) return;
      prev_b = ifc.b[ch];
    end
    checks++;
    errors++;
    $display("FAIL measure_timeout ch%0d actual=no_end expected=pulse_end", ch);
  endtask

  task automatic count_high(input int ch, input int n, output int hits);
    hits = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (ifc.b[ch] || ifc.busy[ch]) hits++;
    end
  endtask

  int bs, bl, ys, yl, np, hits;
  int s0, s1, s2, s3, l0, l1, l2, l3, dx;

  initial begin : stim
    rst_n = 1'b0;
    ifc.a = '0; ifc.en = 1'b1; ifc.edge_sel = 2'b00; ifc.retrig = 1'b0; ifc.width = 10'd5;
    tick(3);
    chk("reset_b", int'(ifc.b), 0);
    chk("reset_busy", int'(ifc.busy), 0);
    rst_n = 1'b1;
    tick(5);

    // Rising edge, width 5
    ifc.a[0] = 1'b1;
    measure(0, bs, bl, ys, yl, np);
    chk("rise_b_start", bs, 3); chk("rise_b_len", bl, 5);
    chk("rise_busy_start", ys, 2); chk("rise_busy_len", yl, 5); chk("rise_npulse", np, 1);
    ifc.a[0] = 1'b0; tick(6);

    // Falling and both-edge modes
    ifc.edge_sel = 2'b01; ifc.a[1] = 1'b1; tick(8);
    ifc.a[1] = 1'b0;
    measure(1, bs, bl, ys, yl, np);
    chk("fall_b_start", bs, 3); chk("fall_b_len", bl, 5);
    tick(4);
    ifc.edge_sel = 2'b10; ifc.a[1] = 1'b1;
    measure(1, bs, bl, ys, yl, np);
    chk("both_up_len", bl, 5); chk("both_up_npulse", np, 1);
    tick(11);
    ifc.a[1] = 1'b0;
    measure(1, bs, bl, ys, yl, np);
    chk("both_dn_start", bs, 3); chk("both_dn_len", bl, 5);
    tick(4);

    // No-edge mode and disabled triggers
    ifc.edge_sel = 2'b11; ifc.a[1] = 1'b1;
    count_high(1, 10, hits); chk("none_mode_hits", hits, 0);
    ifc.a[1] = 1'b0; tick(4);
    ifc.en = 1'b0; ifc.edge_sel = 2'b00; ifc.a[1] = 1'b1;
    count_high(1, 10, hits); chk("en0_hits", hits, 0);
    ifc.en = 1'b1; ifc.a[1] = 1'b0; tick(4);

    // Retrigger with 2 cycles remaining: 2 + 4 cycles continuous
    ifc.retrig = 1'b1; ifc.width = 10'd4; ifc.a[2] = 1'b1;
    fork
      measure(2, bs, bl, ys, yl, np);
      begin tick(1); ifc.a[2] = 1'b0; tick(1); ifc.a[2] = 1'b1; end
    join
    chk("retrig_len", bl, 6); chk("retrig_npulse", np, 1); chk("retrig_busy_len", yl, 6);
    ifc.a[2] = 1'b0; tick(6);
    ifc.retrig = 1'b0; ifc.a[2] = 1'b1;
    fork
      measure(2, bs, bl, ys, yl, np);
      begin tick(1); ifc.a[2] = 1'b0; tick(1); ifc.a[2] = 1'b1; end
    join
    chk("noretrig_len", bl, 4); chk("noretrig_npulse", np, 1);
`ifdef DROP_CNT_EN
    chk("noretrig_drop2", int'(ifc.drop_cnt[23:16]), 1);
`endif
    ifc.a[2] = 1'b0; tick(6);

    // Width 0 and width max
    ifc.width = 10'd0; ifc.a[3] = 1'b1;
    count_high(3, 10, hits); chk("width0_hits", hits, 0);
    ifc.a[3] = 1'b0; tick(4);
    ifc.width = 10'd1023; ifc.a[3] = 1'b1;
    measure(3, bs, bl, ys, yl, np);
    chk("wmax_len", bl, 1023); chk("wmax_busy_start", ys, 2);
    ifc.a[3] = 1'b0; tick(4);

    // Trigger on the terminal cycle is ignored even with retrig
    ifc.width = 10'd3; ifc.retrig = 1'b1; ifc.a[0] = 1'b1;
    fork
      measure(0, bs, bl, ys, yl, np);
      begin tick(1); ifc.a[0] = 1'b0; tick(2); ifc.a[0] = 1'b1; end
    join
    chk("term_len", bl, 3); chk("term_npulse", np, 1);
`ifdef DROP_CNT_EN
    chk("term_drop0", int'(ifc.drop_cnt[7:0]), 1);
`endif
    ifc.a[0] = 1'b0;
    count_high(0, 8, hits); chk("term_after_hits", hits, 0);

    // Asynchronous reset mid-pulse, then a held high across release
    ifc.width = 10'd10; ifc.retrig = 1'b0; ifc.a[1] = 1'b1;
    tick(6);
    chk("rst_pre_busy", int'(ifc.busy[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_b", int'(ifc.b), 0);
    chk("rst_async_busy", int'(ifc.busy), 0);
    tick(2);
    rst_n = 1'b1;
    measure(1, bs, bl, ys, yl, np);
    chk("rst_rel_start", bs, 3); chk("rst_rel_len", bl, 10); chk("rst_rel_npulse", np, 1);
`ifdef DROP_CNT_EN
    chk("rst_drop0", int'(ifc.drop_cnt[7:0]), 0);
`endif
    ifc.a[1] = 1'b0; tick(4);

    // Four channels staggered by one cycle each
    ifc.width = 10'd5;
    fork
      begin ifc.a[0] = 1'b1; measure(0, s0, l0, dx, dx, dx); end
      begin tick(1); ifc.a[1] = 1'b1; measure(1, s1, l1, ys, yl, np); end
      begin tick(2); ifc.a[2] = 1'b1; measure(2, s2, l2, ys, yl, np); end
      begin tick(3); ifc.a[3] = 1'b1; measure(3, s3, l3, bs, bl, hits); end
    join
    chk("stag0_start", s0, 3); chk("stag0_len", l0, 5);
    chk("stag1_start", s1, 3); chk("stag1_len", l1, 5);
    chk("stag2_start", s2, 3); chk("stag2_len", l2, 5);
    chk("stag3_start", s3, 3); chk("stag3_len", l3, 5);
    ifc.a = '0; tick(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
